// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel 8-bit PWM LED driver with duty shadows that update only at period boundaries.
// Optional macro RGB_FADE_EN: at each period boundary the shadows slew toward the target by at most FADE_STEP.
module rgb_pwm_driver #(
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  generate
    if (PRESCALE < 1 || PRESCALE > 65535 || FADE_STEP < 1 || FADE_STEP > 255) begin : g_param_check
      $error("rgb_pwm_driver: PRESCALE or FADE_STEP out of legal range");
    end
  endgenerate

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_r, duty_g, duty_b;
  logic [7:0]  next_r, next_g, next_b;
  logic        tick;
  logic        pend;

  assign tick = (pre_cnt == PRE_LAST);
  assign pend = tick && (pwm_cnt == 8'hFF);

`ifdef RGB_FADE_EN
  localparam logic [8:0] STEP = 9'(FADE_STEP);

  // Nine-bit math keeps cur+STEP and tgt+STEP from wrapping past 255.
  function automatic logic [7:0] fade(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] cur9;
    logic [8:0] tgt9;
    logic [7:0] res;
    cur9 = {1'b0, cur};
    tgt9 = {1'b0, tgt};
    if (tgt9 > cur9) begin
      res = ((cur9 + STEP) > tgt9) ? tgt : 8'(cur9 + STEP);
    end else begin
      res = (cur9 < (tgt9 + STEP)) ? tgt : 8'(cur9 - STEP);
    end
    return res;
  endfunction

  always_comb begin
    next_r = fade(duty_r, light[23:16]);
    next_g = fade(duty_g, light[15:8]);
    next_b = fade(duty_b, light[7:0]);
  end
`else
  always_comb begin
    next_r = light[23:16];
    next_g = light[15:8];
    next_b = light[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      duty_r      <= '0;
      duty_g      <= '0;
      duty_b      <= '0;
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      // Disabled: counters parked at zero, shadows follow light so restart uses the latest colour.
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      duty_r      <= light[23:16];
      duty_g      <= light[15:8];
      duty_b      <= light[7:0];
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (pend) begin
        duty_r <= next_r;
        duty_g <= next_g;
        duty_b <= next_b;
      end
      pwm_r       <= (pwm_cnt < duty_r);
      pwm_g       <= (pwm_cnt < duty_g);
      pwm_b       <= (pwm_cnt < duty_b);
      frame_start <= (pre_cnt == 16'd0) && (pwm_cnt == 8'd0);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: two drivers (PRESCALE 1 and 4) checked every cycle against an elapsed-time model,
// plus directed per-period high-time counts with hand-computed values.
module tb_rgb_pwm_driver;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] light  = 24'h000000;

  logic r1, g1, b1, fs1;
  logic r4, g4, b4, fs4;

  int checks   = 0;
  int failures = 0;
  int printed  = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(16)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .light(light),
    .pwm_r(r1), .pwm_g(g1), .pwm_b(b1), .frame_start(fs1)
  );

  rgb_pwm_driver #(.PRESCALE(4), .FADE_STEP(16)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .light(light),
    .pwm_r(r4), .pwm_g(g4), .pwm_b(b4), .frame_start(fs4)
  );

  // Model: k counts enabled clocks since the run started; position in period is k mod 256*P.
  int         mk [2];
  int         msh[2][3];
  logic [3:0] exp_out[2];
  bit         model_valid = 1'b0;

  function automatic int ps_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int slice(input logic [23:0] l, input int c);
    return int'((l >> (8 * (2 - c))) & 24'hFF);
  endfunction

  function automatic int fade_model(input int cur, input int tgt);
`ifdef RGB_FADE_EN
    if (tgt > cur) return (cur + 16 > tgt) ? tgt : cur + 16;
    return (cur - 16 < tgt) ? tgt : cur - 16;
`else
    return tgt;
`endif
  endfunction

  function automatic logic [3:0] model_out(input int k, input int ps, input int dr, input int dg, input int db);
    int pos;
    int step;
    pos  = k % (256 * ps);
    step = pos / ps;
    return {pos == 0, step < dr, step < dg, step < db};
  endfunction

  always @(posedge clk) begin
    model_valid <= model_valid | rst;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_out[i] <= 4'b0000;
        mk[i]      <= 0;
        for (int c = 0; c < 3; c++) msh[i][c] <= 0;
      end else if (!enable) begin
        exp_out[i] <= 4'b0000;
        mk[i]      <= 0;
        for (int c = 0; c < 3; c++) msh[i][c] <= slice(light, c);
      end else begin
        exp_out[i] <= model_out(mk[i], ps_of(i), msh[i][0], msh[i][1], msh[i][2]);
        if ((mk[i] % (256 * ps_of(i))) == 256 * ps_of(i) - 1) begin
          for (int c = 0; c < 3; c++) msh[i][c] <= fade_model(msh[i][c], slice(light, c));
        end
        mk[i] <= mk[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({fs1, r1, g1, b1} !== exp_out[0]) begin
        failures++;
        if (printed < 20) $display("[TB] FAIL model_p1 t=%0t got={fs,r,g,b}=%b expected=%b", $time, {fs1, r1, g1, b1}, exp_out[0]);
        printed++;
      end
      checks++;
      if ({fs4, r4, g4, b4} !== exp_out[1]) begin
        failures++;
        if (printed < 20) $display("[TB] FAIL model_p4 t=%0t got={fs,r,g,b}=%b expected=%b", $time, {fs4, r4, g4, b4}, exp_out[1]);
        printed++;
      end
    end
  end

  int hr1, hg1, hb1, hr4, fsc1, fsc4, fsfirst1, fsfirst4;

  task automatic applyStimulus(input logic r, input logic e, input logic [23:0] l);
    rst    = r;
    enable = e;
    light  = l;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sampleWindow(input int n);
    hr1 = 0; hg1 = 0; hb1 = 0; hr4 = 0; fsc1 = 0; fsc4 = 0; fsfirst1 = -1; fsfirst4 = -1;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      hr1 += int'(r1); hg1 += int'(g1); hb1 += int'(b1); hr4 += int'(r4);
      if (fs1) begin
        fsc1++;
        if (fsfirst1 < 0) fsfirst1 = s;
      end
      if (fs4) begin
        fsc4++;
        if (fsfirst4 < 0) fsfirst4 = s;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

`ifdef RGB_FADE_EN
  localparam int MID_NEXT   = 48;
  localparam int RST_SECOND = 16;
  localparam int AT100_HIGH = 0;
  localparam int FADE_EXP[6] = '{0, 16, 32, 48, 64, 64};
`else
  localparam int MID_NEXT   = 240;
  localparam int RST_SECOND = 240;
  localparam int AT100_HIGH = 1;
  localparam int FADE_EXP[6] = '{0, 64, 64, 64, 64, 64};
`endif

  initial begin
    int half4;
    int first4;
    int cnt;
    $display("[TB] start");
    clocks(2);
    checkOutput("reset_outputs", int'({fs1, r1, g1, b1, fs4, r4, g4, b4}), 0);

    // Colour 8000FF loaded while disabled, then run.
    applyStimulus(1'b0, 1'b0, 24'h8000FF);
    clocks(3);
    applyStimulus(1'b0, 1'b1, 24'h8000FF);
    sampleWindow(256);
    checkOutput("p1_r_high", hr1, 128);
    checkOutput("p1_g_high", hg1, 0);
    checkOutput("p1_b_high", hb1, 255);
    checkOutput("p1_fs_count", fsc1, 1);
    checkOutput("p1_fs_first", fsfirst1, 0);
    half4 = hr4;
    sampleWindow(768);
    checkOutput("p4_r_high_80", half4 + hr4, 512);

    // PRESCALE 4 with R duty 0x10.
    applyStimulus(1'b0, 1'b0, 24'h100000);
    clocks(2);
    applyStimulus(1'b0, 1'b1, 24'h100000);
    sampleWindow(1024);
    checkOutput("p4_r_high_10", hr4, 64);
    checkOutput("p4_fs_count", fsc4, 1);
    checkOutput("p4_fs_first", fsfirst4, 0);
    checkOutput("p1_r_high_4periods", hr1, 64);
    checkOutput("p1_fs_4periods", fsc1, 4);
    first4 = fsfirst4;
    sampleWindow(1024);
    checkOutput("p4_fs_spacing", 1024 + fsfirst4 - first4, 1024);

    // Mid-period light change at count 10.
    applyStimulus(1'b0, 1'b0, 24'h200000);
    clocks(2);
    applyStimulus(1'b0, 1'b1, 24'h200000);
    sampleWindow(10);
    cnt = hr1;
    applyStimulus(1'b0, 1'b1, 24'hF00000);
    sampleWindow(246);
    checkOutput("mid_current_period", cnt + hr1, 32);
    sampleWindow(256);
    checkOutput("mid_next_period", hr1, MID_NEXT);

    // Reset pulse at count 100.
    sampleWindow(100);
    checkOutput("pre_reset_r", int'(r1), AT100_HIGH);
    applyStimulus(1'b1, 1'b1, 24'hF00000);
    clocks(1);
    checkOutput("mid_reset_outputs", int'({fs1, r1, g1, b1, fs4, r4, g4, b4}), 0);
    applyStimulus(1'b0, 1'b1, 24'hF00000);
    sampleWindow(256);
    checkOutput("post_reset_dark", hr1, 0);
    checkOutput("post_reset_fs", fsc1, 1);
    sampleWindow(256);
    checkOutput("post_reset_second", hr1, RST_SECOND);

    // Enable drop at count 50, restart with newly sampled light.
    sampleWindow(50);
    applyStimulus(1'b0, 1'b0, 24'h300000);
    clocks(1);
    checkOutput("disable_outputs", int'({fs1, r1, g1, b1, fs4, r4, g4, b4}), 0);
    sampleWindow(4);
    checkOutput("disabled_no_fs", fsc1 + fsc4, 0);
    applyStimulus(1'b0, 1'b1, 24'h300000);
    sampleWindow(256);
    checkOutput("restart_r_high", hr1, 48);
    checkOutput("restart_fs_first", fsfirst1, 0);

    // Shadow starts at 0, target R=0x40 arrives during the first period.
    applyStimulus(1'b0, 1'b0, 24'h000000);
    clocks(1);
    applyStimulus(1'b0, 1'b1, 24'h000000);
    sampleWindow(5);
    cnt = hr1;
    applyStimulus(1'b0, 1'b1, 24'h400000);
    sampleWindow(251);
    checkOutput("fade_period0", cnt + hr1, FADE_EXP[0]);
    for (int p = 1; p < 6; p++) begin
      sampleWindow(256);
      checkOutput($sformatf("fade_period%0d", p), hr1, FADE_EXP[p]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
